// File: rtl/interval_timer_if.sv
// rtl/interval_timer_if.sv - control/status bundle for interval_timer
interface interval_timer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             busy;

    modport master (
        output start, stop, periodic, target,
        input  count, tick, done, busy
    );

    modport slave (
        input  start, stop, periodic, target,
        output count, tick, done, busy
    );
endinterface

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - runtime-loadable interval timer with prescaler, one-shot/periodic modes
module interval_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset,
    interval_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             step;

    // A zero target would never reach a terminal count, so such a start is ignored.
    assign accept = bus.start && (bus.target != '0);

    generate
        if (PRESCALE == 1) begin : g_no_presc
            assign step = 1'b1;
        end else begin : g_presc
            localparam int            PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
            logic [PW-1:0] presc_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    presc_q <= '0;
                end else if (accept || bus.stop || (state_q != RUN)) begin
                    presc_q <= '0;
                end else if (presc_q == PMAX) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end

            assign step = (presc_q == PMAX);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        done_d   = done_q;
        busy_d   = busy_q;

        // Priority: restart, then abort, then normal counting.
        if (accept) begin
            target_d = bus.target;
            mode_d   = bus.periodic;
            count_d  = '0;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
        end else if (bus.stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && step) begin
            if (count_q == (target_q - WIDTH'(1))) begin
                tick_d = 1'b1;
                if (mode_q) begin
                    count_d = '0;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - directed self-checking bench for interval_timer
module tb_interval_timer;
    logic        clk;
    logic        rst_n;
    logic        start_s;
    logic        stop_s;
    logic        periodic_s;
    logic [15:0] target_s;
    int          checks;
    int          failures;

    interval_timer_if #(.WIDTH(16)) if_a ();
    interval_timer_if #(.WIDTH(16)) if_b ();
    interval_timer_if #(.WIDTH(4))  if_c ();

    assign if_a.start = start_s;  assign if_a.stop = stop_s;
    assign if_a.periodic = periodic_s;  assign if_a.target = target_s;
    assign if_b.start = start_s;  assign if_b.stop = stop_s;
    assign if_b.periodic = periodic_s;  assign if_b.target = target_s;
    assign if_c.start = start_s;  assign if_c.stop = stop_s;
    assign if_c.periodic = periodic_s;  assign if_c.target = target_s[3:0];

    interval_timer #(.WIDTH(16), .PRESCALE(1)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
    interval_timer #(.WIDTH(16), .PRESCALE(3)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b));
    interval_timer #(.WIDTH(4),  .PRESCALE(1)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] n, input logic per);
        target_s = n; periodic_s = per; start_s = 1'b1;
        cyc(1);
        start_s = 1'b0;
    endtask

    task automatic do_stop();
        stop_s = 1'b1;
        cyc(1);
        stop_s = 1'b0;
    endtask

    task automatic test_reset();
        cyc(2);
        checks++; if (if_a.count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", if_a.count); end
        checks++; if ({if_a.tick, if_a.done, if_a.busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {if_a.tick, if_a.done, if_a.busy}); end
        rst_n = 1'b1;
        cyc(1);
        do_start(16'd5, 1'b1);
        cyc(3);
        checks++; if (if_a.count !== 16'd3) begin failures++; $display("FAIL prereset_count got=%0d exp=3", if_a.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if_a.count !== 16'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", if_a.count); end
        checks++; if ({if_a.tick, if_a.done, if_a.busy} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got=%b exp=000", {if_a.tick, if_a.done, if_a.busy}); end
        cyc(3);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            checks++; if ({if_a.tick, if_a.busy} !== 2'b00) begin failures++; $display("FAIL post_reset_idle k=%0d got=%b exp=00", k, {if_a.tick, if_a.busy}); end
        end
    endtask

    task automatic test_oneshot();
        do_start(16'd4, 1'b0);
        checks++; if ({if_a.count, if_a.busy, if_a.tick} !== {16'd0, 2'b10}) begin failures++; $display("FAIL os_start got=%0d/%b%b exp=0/10", if_a.count, if_a.busy, if_a.tick); end
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            checks++; if (if_a.count !== 16'((k < 4) ? k : 3)) begin failures++; $display("FAIL os_count k=%0d got=%0d exp=%0d", k, if_a.count, (k < 4) ? k : 3); end
            checks++; if ({if_a.tick, if_a.done, if_a.busy} !== ((k == 4) ? 3'b110 : 3'b001)) begin failures++; $display("FAIL os_flags k=%0d got=%b exp=%b", k, {if_a.tick, if_a.done, if_a.busy}, (k == 4) ? 3'b110 : 3'b001); end
        end
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            checks++; if ({if_a.count, if_a.tick, if_a.done, if_a.busy} !== {16'd3, 3'b010}) begin failures++; $display("FAIL os_hold k=%0d got=%0d/%b exp=3/010", k, if_a.count, {if_a.tick, if_a.done, if_a.busy}); end
        end
    endtask

    task automatic test_periodic();
        int nticks;
        nticks = 0;
        do_start(16'd2, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            if (if_b.tick === 1'b1) nticks++;
            checks++; if (if_b.tick !== ((k % 6) == 0)) begin failures++; $display("FAIL per_tick k=%0d got=%b exp=%b", k, if_b.tick, (k % 6) == 0); end
            checks++; if (if_b.count !== 16'(((k % 6) >= 3) ? 1 : 0)) begin failures++; $display("FAIL per_count k=%0d got=%0d exp=%0d", k, if_b.count, ((k % 6) >= 3) ? 1 : 0); end
            checks++; if (if_b.busy !== 1'b1) begin failures++; $display("FAIL per_busy k=%0d got=%b exp=1", k, if_b.busy); end
        end
        checks++; if (nticks != 5) begin failures++; $display("FAIL per_nticks got=%0d exp=5", nticks); end
        do_stop();
    endtask

    task automatic test_stop();
        do_start(16'd10, 1'b0);
        cyc(7);
        checks++; if (if_a.count !== 16'd7) begin failures++; $display("FAIL stop_precount got=%0d exp=7", if_a.count); end
        do_stop();
        checks++; if ({if_a.count, if_a.tick, if_a.done, if_a.busy} !== {16'd7, 3'b000}) begin failures++; $display("FAIL stop_state got=%0d/%b exp=7/000", if_a.count, {if_a.tick, if_a.done, if_a.busy}); end
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            checks++; if ({if_a.count, if_a.tick, if_a.done} !== {16'd7, 2'b00}) begin failures++; $display("FAIL stop_hold k=%0d got=%0d/%b exp=7/00", k, if_a.count, {if_a.tick, if_a.done}); end
        end
        do_start(16'd0, 1'b0);
        cyc(2);
        checks++; if ({if_a.count, if_a.busy} !== {16'd7, 1'b0}) begin failures++; $display("FAIL zero_target got=%0d/%b exp=7/0", if_a.count, if_a.busy); end
    endtask

    task automatic test_collision();
        do_start(16'd10, 1'b0);
        cyc(3);
        target_s = 16'd10; start_s = 1'b1; stop_s = 1'b1;
        cyc(1);
        start_s = 1'b0; stop_s = 1'b0;
        checks++; if ({if_a.count, if_a.busy} !== {16'd0, 1'b1}) begin failures++; $display("FAIL start_stop got=%0d/%b exp=0/1", if_a.count, if_a.busy); end
        cyc(9);
        checks++; if (if_a.count !== 16'd9) begin failures++; $display("FAIL pre_term_count got=%0d exp=9", if_a.count); end
        do_stop();
        checks++; if ({if_a.count, if_a.tick, if_a.done, if_a.busy} !== {16'd9, 3'b000}) begin failures++; $display("FAIL stop_on_term got=%0d/%b exp=9/000", if_a.count, {if_a.tick, if_a.done, if_a.busy}); end
        cyc(1);
        checks++; if (if_a.tick !== 1'b0) begin failures++; $display("FAIL stop_on_term_late got=%b exp=0", if_a.tick); end
        do_start(16'd5, 1'b0);
        cyc(4);
        do_start(16'd3, 1'b0);
        checks++; if ({if_a.count, if_a.tick, if_a.busy} !== {16'd0, 2'b01}) begin failures++; $display("FAIL restart_on_term got=%0d/%b exp=0/01", if_a.count, {if_a.tick, if_a.busy}); end
        cyc(2);
        checks++; if ({if_a.count, if_a.tick} !== {16'd2, 1'b0}) begin failures++; $display("FAIL restart_mid got=%0d/%b exp=2/0", if_a.count, if_a.tick); end
        cyc(1);
        checks++; if ({if_a.tick, if_a.done} !== 2'b11) begin failures++; $display("FAIL restart_tick got=%b exp=11", {if_a.tick, if_a.done}); end
    endtask

    task automatic test_extremes();
        do_start(16'd15, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            checks++; if (if_c.count !== 4'((k < 15) ? k : 14)) begin failures++; $display("FAIL ext_count k=%0d got=%0d exp=%0d", k, if_c.count, (k < 15) ? k : 14); end
            checks++; if (if_c.tick !== (k == 15)) begin failures++; $display("FAIL ext_tick k=%0d got=%b exp=%b", k, if_c.tick, k == 15); end
        end
        cyc(3);
        checks++; if ({if_c.count, if_c.done, if_c.busy} !== {4'd14, 2'b10}) begin failures++; $display("FAIL ext_hold got=%0d/%b exp=14/10", if_c.count, {if_c.done, if_c.busy}); end
        do_start(16'd1, 1'b1);
        checks++; if (if_c.tick !== 1'b0) begin failures++; $display("FAIL n1_first got=%b exp=0", if_c.tick); end
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            checks++; if ({if_c.count, if_c.tick, if_c.busy} !== {4'd0, 2'b11}) begin failures++; $display("FAIL n1_tick k=%0d got=%0d/%b exp=0/11", k, if_c.count, {if_c.tick, if_c.busy}); end
        end
        do_stop();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start_s = 1'b0; stop_s = 1'b0; periodic_s = 1'b0; target_s = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_collision();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Parametrised successor to the single-target clock counter. Runtime-loadable target, optional prescaler, one-shot or periodic mode, start/stop control, and status outputs. It sits beside the standard ICs and generates timed events (debounce windows, scan periods, protocol timeouts) for the peripheral FSMs.

Parameters:
WIDTH, 16, width of target and count; targets 1 .. 2^WIDTH-1 are supported.
PRESCALE, 1, clk cycles per count step; must be >= 1; 1 = step every cycle.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
start  input  1  level sampled each posedge; starts or restarts the timer.
stop  input  1  level sampled each posedge; aborts the run and returns to IDLE.
periodic  input  1  mode, sampled only when start is accepted; 1 = periodic, 0 = one-shot.
target  input  WIDTH  count length N, sampled only when start is accepted.
count  output  WIDTH  current step count, 0 .. N-1.
tick  output  1  registered one-cycle pulse at each terminal count.
done  output  1  sticky one-shot completion flag.
busy  output  1  1 while in RUN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; count=0, tick=0, done=0, busy=0; prescaler=0; latched target/mode cleared. Reset asserted mid-run aborts the run immediately, with no tick.
- States: IDLE, RUN, DONE. There is only one state register. All outputs are registered.
- Start accepted (start=1, target!=0, any state):
  - latch target_q=target and mode_q=periodic;
  - count=0, prescaler=0, done=0, tick=0, busy=1, state=RUN.
- Start with target==0: ignored; state and outputs are unchanged.
- Step: in RUN, a step occurs on the edge where prescaler==PRESCALE-1. Prescaler counts 0..PRESCALE-1 and wraps. With PRESCALE=1 every edge is a step, and no prescaler logic is generated beyond a constant.
- On a non-terminal step (count!=target_q-1): count<=count+1.
- On a terminal step (count==target_q-1):
  - tick<=1 for exactly one cycle.
  - Periodic: count<=0; stay in RUN; busy stays 1.
  - One-shot: count holds at target_q-1; done<=1, busy<=0, state=DONE.
- Latency: the first tick is visible exactly N*PRESCALE cycles after the edge that accepted start. In periodic mode, ticks repeat every N*PRESCALE cycles.
- Stop (start=0, stop=1):
  - From any state: go to IDLE; busy=0, done=0, tick=0.
  - count holds its value, which is readable for elapsed-time capture.
  - Prescaler resets to 0.
- Simultaneous events:
  - start and stop together: start wins, i.e. restart.
  - stop on a terminal step: stop wins; no tick, no done.
  - start on a terminal step: restart wins; no tick.
- DONE holds until start, stop or reset; a one-shot never retriggers by itself.
- Arithmetic: count is compared only to target_q-1, computed in WIDTH bits (target_q!=0 guaranteed). count never wraps past target_q-1. Changing target or periodic during RUN has no effect until the next accepted start.
- tick is never high for two consecutive cycles unless N*PRESCALE==1 in periodic mode, in which case tick stays high every cycle.

Test Plan:
1. Reset: hold reset=0 for 3 cycles mid-run (periodic, N=5) -> count=0, tick=0, done=0, busy=0 immediately, without waiting for a clk edge; no tick after release until a new start.
2. One-shot, PRESCALE=1, target=4 -> count 0,1,2,3, then holds 3; tick high exactly once, in cycle 4 after the start edge; done=1 and busy=0 from that cycle; done stays 1 for 20 more cycles.
3. Periodic, PRESCALE=3, target=2 -> tick every 6 cycles, first 6 cycles after start; 5 consecutive ticks; busy stays 1; count sequence 0,0,0,1,1,1 repeats.
4. Stop at count=7 (one-shot, target=10) -> IDLE, busy=0, count holds 7, no tick or done; start with target=0 afterwards -> ignored, count still 7.
5. Collisions: start+stop together during RUN -> restart, count=0, busy=1. stop on the terminal edge -> no tick. Restart on the terminal edge with target=3 -> no tick, next tick 3 cycles later.
6. Extremes, WIDTH=4: target=15 one-shot -> tick after 15 cycles, count max 14, no wrap. target=1 periodic with PRESCALE=1 -> tick high every cycle.
